// File: rtl/free_list_pkg.sv
// Shared sizing and tag types for the rename free list.
package free_list_pkg;
    localparam int NUM_PR  = 64;
    localparam int NUM_ROB = 32;
    localparam int NUM_FL  = NUM_PR - 32;

    typedef logic [$clog2(NUM_PR)-1:0] T_idx_t;
    typedef logic [$clog2(NUM_FL):0]   FL_PTR_t;
endpackage

// File: rtl/free_list.sv
// Circular free list of physical register tags with per-ROB-slot head
// checkpoints so a mispredicted branch can restore the head pointer.
module free_list #(
    parameter int NUM_PR  = free_list_pkg::NUM_PR,
    parameter int NUM_ROB = free_list_pkg::NUM_ROB,
    parameter int NUM_FL  = NUM_PR - 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       dispatch_en,
    input  logic [$clog2(NUM_ROB)-1:0] ROB_tail_idx,
    input  logic                       retire_en,
    input  logic [$clog2(NUM_PR)-1:0]  retire_T_old,
    input  logic                       rollback_en,
    input  logic [$clog2(NUM_ROB)-1:0] ROB_rollback_idx,
    output logic [$clog2(NUM_PR)-1:0]  T_idx,
    output logic                       free_valid,
    output logic [$clog2(NUM_FL):0]    free_count
);
    import free_list_pkg::*;

    localparam int TAG_W = $clog2(NUM_PR);
    localparam int IDX_W = $clog2(NUM_FL);
    localparam int PTR_W = IDX_W + 1;

    logic [TAG_W-1:0] fl_buf_q [NUM_FL];
    logic [TAG_W-1:0] fl_buf_d [NUM_FL];
    logic [PTR_W-1:0] chkpt_q  [NUM_ROB];
    logic [PTR_W-1:0] chkpt_d  [NUM_ROB];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             full;

    assign free_count = tail_q - head_q;
    assign free_valid = (free_count != '0);
    assign full       = (free_count == PTR_W'(NUM_FL));
    assign T_idx      = fl_buf_q[head_q[IDX_W-1:0]];

    // Rollback wins over dispatch for the head; retire only moves the tail,
    // so the two are independent and may both happen in one cycle.
    always_comb begin
        fl_buf_d = fl_buf_q;
        chkpt_d  = chkpt_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (en) begin
            if (rollback_en) begin
                head_d = chkpt_q[ROB_rollback_idx];
            end else if (dispatch_en && free_valid) begin
                head_d                = head_q + 1'b1;
                chkpt_d[ROB_tail_idx] = head_q + 1'b1;
            end
            if (retire_en && !full) begin
                fl_buf_d[tail_q[IDX_W-1:0]] = retire_T_old;
                tail_d                      = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FL; i++) begin
                fl_buf_q[i] <= TAG_W'(32 + i);
            end
            for (int i = 0; i < NUM_ROB; i++) begin
                chkpt_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            fl_buf_q <= fl_buf_d;
            chkpt_q  <= chkpt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    // Retiring into a full list means a tag was freed twice upstream.
    a_no_retire_when_full: assert property (
        @(posedge clock) disable iff (reset) !(en && retire_en && full)
    );

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed checks of free_list against an unbounded-log model
// of the free tag sequence with integer head/tail positions.
module tb_free_list;
    import free_list_pkg::*;

    logic       clock;
    logic       reset;
    logic       en;
    logic       dispatch_en;
    logic [4:0] ROB_tail_idx;
    logic       retire_en;
    logic [5:0] retire_T_old;
    logic       rollback_en;
    logic [4:0] ROB_rollback_idx;
    T_idx_t     T_idx;
    logic       free_valid;
    FL_PTR_t    free_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: every tag ever placed in the list, addressed by unbounded position.
    int m_seq [int];
    int m_head;
    int m_tail;
    int m_ckpt [32];
    int in_use [$];

    free_list dut (
        .clock(clock), .reset(reset), .en(en), .dispatch_en(dispatch_en),
        .ROB_tail_idx(ROB_tail_idx), .retire_en(retire_en),
        .retire_T_old(retire_T_old), .rollback_en(rollback_en),
        .ROB_rollback_idx(ROB_rollback_idx), .T_idx(T_idx),
        .free_valid(free_valid), .free_count(free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_seq.delete();
        for (int i = 0; i < 32; i++) m_seq[i] = 32 + i;
        m_head = 0;
        m_tail = 32;
        for (int i = 0; i < 32; i++) m_ckpt[i] = 0;
        in_use.delete();
    endtask

    // Drive one cycle at the negedge, advance the model, sample 1ns after the edge.
    task automatic applyStimulus(input bit r, input bit e, input bit d, input int rob,
                                 input bit re, input int tag, input bit rb, input int rbi);
        int cnt;
        @(negedge clock);
        reset = r; en = e; dispatch_en = d; ROB_tail_idx = 5'(rob);
        retire_en = re; retire_T_old = 6'(tag);
        rollback_en = rb; ROB_rollback_idx = 5'(rbi);
        cnt = m_tail - m_head;
        if (r) begin
            modelReset();
        end else if (e) begin
            if (rb) begin
                m_head = m_ckpt[rbi];
            end else if (d && cnt > 0) begin
                m_ckpt[rob] = m_head + 1;
                m_head++;
            end
            if (re && cnt < 32) begin
                m_seq[m_tail] = tag;
                m_tail++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic checkModel(input string tag);
        int cnt;
        cnt = m_tail - m_head;
        checkOutput({tag, "_count"}, int'(free_count), cnt);
        checkOutput({tag, "_valid"}, int'(free_valid), (cnt > 0) ? 1 : 0);
        if (cnt > 0) checkOutput({tag, "_tidx"}, int'(T_idx), m_seq[m_head]);
    endtask

    initial begin
        int obs;
        int dup;
        int pick;
        bit do_d;
        bit do_r;
        bit do_e;
        reset = 1'b1; en = 1'b0; dispatch_en = 1'b0; ROB_tail_idx = '0;
        retire_en = 1'b0; retire_T_old = '0; rollback_en = 1'b0; ROB_rollback_idx = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_tidx", int'(T_idx), 32);
        checkOutput("reset_valid", int'(free_valid), 1);
        checkOutput("reset_count", int'(free_count), 32);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, i, 0, 0, 0, 0);
            checkModel("pop3");
        end
        checkOutput("pop3_tidx_35", int'(T_idx), 35);
        checkOutput("pop3_count_29", int'(free_count), 29);

        for (int i = 0; i < 29; i++) applyStimulus(0, 1, 1, i, 0, 0, 0, 0);
        checkModel("drained");
        applyStimulus(0, 1, 1, 9, 0, 0, 0, 0);
        checkOutput("empty_count", int'(free_count), 0);
        checkOutput("empty_valid", int'(free_valid), 0);
        applyStimulus(0, 1, 0, 0, 1, 5, 0, 0);
        checkOutput("refill_tidx", int'(T_idx), 5);
        checkOutput("refill_count", int'(free_count), 1);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 3, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 4, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 5, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 3);
        checkOutput("rollback_tidx", int'(T_idx), 33);
        checkOutput("rollback_count", int'(free_count), 31);

        applyStimulus(0, 1, 1, 6, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 7, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 8, 1, 7, 1, 6);
        checkOutput("rb_ret_tidx", int'(T_idx), 34);
        checkOutput("rb_ret_count", int'(free_count), 31);
        checkModel("rb_ret");

        // Random dispatch/retire across several pointer wraps.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 100; cyc++) begin
            do_e = ($urandom_range(9) != 0);
            do_d = ($urandom_range(9) < 7);
            do_r = (in_use.size() > 0) && ($urandom_range(1) == 1);
            pick = do_r ? int'($urandom_range(in_use.size() - 1)) : 0;
            obs  = int'(T_idx);
            if (do_e && do_d && (m_tail - m_head) > 0) begin
                dup = 0;
                foreach (in_use[k]) if (in_use[k] == obs) dup = 1;
                checkOutput("no_dup_tag", dup, 0);
            end
            if (do_r) begin
                applyStimulus(0, do_e, do_d, int'($urandom_range(31)), 1, in_use[pick], 0, 0);
                if (do_e) in_use.delete(pick);
            end else begin
                applyStimulus(0, do_e, do_d, int'($urandom_range(31)), 0, 0, 0, 0);
            end
            if (do_e && do_d && (m_head > 0) && (m_tail - m_head) >= 0) begin
                // A pop occurred iff the model head moved; record the tag taken.
            end
            checkModel("rand");
            if (do_e && do_d && obs == m_seq[m_head - 1] && !in_use_has(obs)) in_use.push_back(obs);
        end

        applyStimulus(0, 1, 1, 2, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 2, 1, 3, 0, 0);
        checkOutput("midreset_tidx", int'(T_idx), 32);
        checkOutput("midreset_valid", int'(free_valid), 1);
        checkOutput("midreset_count", int'(free_count), 32);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    function automatic bit in_use_has(input int t);
        foreach (in_use[k]) if (in_use[k] == t) return 1'b1;
        return 1'b0;
    endfunction

endmodule
